// File: rtl/burner_sequencer.sv
// burner_sequencer: burner-management FSM driving purge, ignition trials, flame proving, run, post-purge and trips
module burner_sequencer #(
    parameter int PURGE_CYCLES = 16,
    parameter int IGN_CYCLES   = 8,
    parameter int PROVE_CYCLES = 4,
    parameter int COOL_CYCLES  = 32,
    parameter int MAX_RETRIES  = 3,
    parameter int MIN_FLOW     = 10,
    parameter int CO_LIMIT     = 100,
    parameter int ETH_LIMIT    = 50,
    parameter int TEMP_MAX     = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        lockout_clr,
    input  logic        flame,
    input  logic [7:0]  CO,
    input  logic [7:0]  ethanol,
    input  logic [11:0] massflow,
    input  logic [15:0] temperature,
    input  logic        fault,
    output logic        fan,
    output logic        valve,
    output logic        solenoid,
    output logic        pump,
    output logic        igniter,
    output logic        alarm,
    output logic        lockout,
    output logic [2:0]  state,
    output logic [1:0]  retry_cnt
);
    typedef enum logic [2:0] {IDLE, PURGE, IGNITE, PROVE, RUN, POSTPURGE, ALARM, LOCKOUT} state_t;
    state_t cur, nxt, fail_dst;
    logic [15:0] timer;
    logic [1:0] retry_nxt, retry_inc;
    logic hazard, fail;
    assign state = cur;
    assign hazard = (CO > 8'(CO_LIMIT)) | (ethanol > 8'(ETH_LIMIT)) | (temperature > 16'(TEMP_MAX)) | fault;
    assign fail = (cur == IGNITE && !flame && timer == 16'(IGN_CYCLES - 1)) || (cur == PROVE && !flame);
    assign retry_inc = retry_cnt == 2'd3 ? 2'd3 : retry_cnt + 2'd1;
    assign fail_dst = ({1'b0, retry_cnt} + 3'd1 == 3'(MAX_RETRIES)) ? LOCKOUT : PURGE;
    always_comb begin
        nxt = cur;
        retry_nxt = retry_cnt;
        case (cur)
            IDLE: if (start && !stop && !hazard && massflow > 12'(MIN_FLOW)) begin
                nxt = PURGE;
                retry_nxt = 2'd0;
            end
            PURGE: nxt = hazard ? ALARM : stop ? POSTPURGE : timer == 16'(PURGE_CYCLES - 1) ? IGNITE : PURGE;
            IGNITE, PROVE: begin
                if (hazard) nxt = ALARM;
                else if (stop) nxt = POSTPURGE;
                else if (cur == IGNITE && flame) nxt = PROVE;
                else if (fail) begin
                    nxt = fail_dst;
                    retry_nxt = retry_inc;
                end else if (cur == PROVE && timer == 16'(PROVE_CYCLES - 1)) begin
                    nxt = RUN;
                    retry_nxt = 2'd0;
                end
            end
            // flame loss in RUN is handled with hazard priority
            RUN: nxt = (hazard || !flame) ? ALARM : stop ? POSTPURGE : RUN;
            POSTPURGE: nxt = hazard ? ALARM : timer == 16'(COOL_CYCLES - 1) ? IDLE : POSTPURGE;
            ALARM: nxt = (!hazard && timer >= 16'(COOL_CYCLES - 1)) ? IDLE : ALARM;
            LOCKOUT: nxt = (lockout_clr && !hazard) ? IDLE : LOCKOUT;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= IDLE;
            timer     <= 16'd0;
            retry_cnt <= 2'd0;
            {fan, valve, solenoid, pump, igniter, alarm, lockout} <= 7'd0;
        end else begin
            cur       <= nxt;
            timer     <= nxt != cur ? 16'd0 : timer == 16'hFFFF ? timer : timer + 16'd1;
            retry_cnt <= retry_nxt;
            fan       <= nxt != IDLE;
            valve     <= nxt inside {IGNITE, PROVE, RUN};
            solenoid  <= nxt inside {IGNITE, PROVE, RUN};
            pump      <= nxt == RUN;
            igniter   <= nxt == IGNITE;
            alarm     <= nxt inside {ALARM, LOCKOUT};
            lockout   <= nxt == LOCKOUT;
        end
    end
endmodule

// File: tb/tb_burner_sequencer.sv
// tb_burner_sequencer: directed checks of light-off, retries, lockout, trips, thresholds and reset
module tb_burner_sequencer;
    logic clk = 0, reset = 1, start = 0, stop = 0, lockout_clr = 0, flame = 0, fault = 0;
    logic [7:0] CO = 0, ethanol = 0;
    logic [11:0] massflow = 0;
    logic [15:0] temperature = 0;
    logic fan, valve, solenoid, pump, igniter, alarm, lockout;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    int checks = 0, errors = 0;
    burner_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .lockout_clr(lockout_clr),
        .flame(flame), .CO(CO), .ethanol(ethanol), .massflow(massflow),
        .temperature(temperature), .fault(fault), .fan(fan), .valve(valve),
        .solenoid(solenoid), .pump(pump), .igniter(igniter), .alarm(alarm),
        .lockout(lockout), .state(state), .retry_cnt(retry_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    function automatic logic [6:0] outs();
        return {fan, valve, solenoid, pump, igniter, alarm, lockout};
    endfunction
    initial begin
        step(2);
        chk("reset_state", state, 0);
        chk("reset_outs", outs(), 7'b0000000);
        chk("reset_retry", retry_cnt, 0);
        reset = 0;
        // nominal light-off
        massflow = 20; start = 1;
        step(1);
        chk("purge_enter", state, 1);
        chk("purge_outs", outs(), 7'b1000000);
        start = 0;
        step(15);
        chk("purge_hold", state, 1);
        step(1);
        chk("ignite_enter", state, 2);
        chk("ignite_outs", outs(), 7'b1110100);
        step(2); flame = 1;
        step(1);
        chk("prove_enter", state, 3);
        chk("prove_outs", outs(), 7'b1110000);
        step(3);
        chk("prove_hold", state, 3);
        step(1);
        chk("run_enter", state, 4);
        chk("run_outs", outs(), 7'b1111000);
        chk("run_retry", retry_cnt, 0);
        // gas trip in RUN, cleared at alarm cycle 10
        CO = 101;
        step(1);
        chk("gas_alarm", state, 6);
        chk("gas_alarm_outs", outs(), 7'b1000010);
        step(10); CO = 100;
        step(21);
        chk("alarm_dwell", state, 6);
        step(1);
        chk("alarm_exit", state, 0);
        // hazard blocks start in IDLE
        flame = 0; CO = 101; start = 1;
        step(1);
        chk("idle_hazard_block", state, 0);
        CO = 100;
        step(1);
        chk("purge_again", state, 1);
        start = 0; CO = 101;
        step(1);
        chk("purge_trip", state, 6);
        step(49);
        chk("alarm_held", state, 6);
        CO = 100;
        step(1);
        chk("alarm_release", state, 0);
        // start and stop together
        start = 1; stop = 1;
        step(1);
        chk("start_stop_idle", state, 0);
        stop = 0;
        // thresholds
        ethanol = 50; temperature = 1000; massflow = 10;
        step(1);
        chk("flow_10_ignored", state, 0);
        massflow = 11;
        step(1);
        chk("flow_11_accepted", state, 1);
        start = 0;
        // retry to lockout with flame held low
        step(16);
        chk("retry_ign1", state, 2);
        step(7);
        chk("ign_window", state, 2);
        step(1);
        chk("retry1_state", state, 1);
        chk("retry1_cnt", retry_cnt, 1);
        step(16);
        chk("retry_ign2", state, 2);
        step(8);
        chk("retry2_state", state, 1);
        chk("retry2_cnt", retry_cnt, 2);
        step(24);
        chk("lockout_state", state, 7);
        chk("lockout_outs", outs(), 7'b1000011);
        lockout_clr = 1; fault = 1;
        step(1);
        chk("lockout_fault_hold", state, 7);
        fault = 0;
        step(1);
        chk("lockout_clear", state, 0);
        lockout_clr = 0; ethanol = 0; temperature = 0; massflow = 20;
        // flame flicker in PROVE
        start = 1;
        step(1);
        chk("flicker_purge", state, 1);
        chk("flicker_retry0", retry_cnt, 0);
        start = 0;
        step(16); flame = 1;
        step(1);
        chk("flicker_prove", state, 3);
        step(1); flame = 0;
        step(1);
        chk("flicker_fail", state, 1);
        chk("flicker_retry1", retry_cnt, 1);
        step(16); flame = 1;
        step(5);
        chk("run2", state, 4);
        chk("run2_retry", retry_cnt, 0);
        stop = 1;
        step(1);
        chk("postpurge", state, 5);
        chk("postpurge_outs", outs(), 7'b1000000);
        step(31);
        chk("postpurge_hold", state, 5);
        step(1);
        chk("postpurge_exit", state, 0);
        stop = 0; flame = 0;
        // reset mid-IGNITE
        start = 1;
        step(1); start = 0;
        step(16);
        chk("rst_ign", state, 2);
        step(3); reset = 1;
        step(1);
        chk("rst_state", state, 0);
        chk("rst_outs", outs(), 7'b0000000);
        chk("rst_retry", retry_cnt, 0);
        reset = 0;
        // flame coincides with the IGNITE timeout
        start = 1;
        step(1); start = 0;
        step(16);
        step(7);
        chk("timeout_cycle", state, 2);
        flame = 1;
        step(1);
        chk("flame_wins", state, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/burner_sequencer.md
Name: burner_sequencer

Overview:
Supervisory burner-management sequencer for the furnace datapath. It drives fan, gas valve, fuel solenoid, pump and igniter through purge, ignition trials, flame proving, run and post-purge. It also enforces gas, over-temperature and fault trips, with a latched lockout after repeated failed ignitions. It sits between the operator/host controls and the actuator drivers, and replaces open-loop state stepping.

Parameters:
PURGE_CYCLES, 16, pre-purge dwell in clk cycles (>=2)
IGN_CYCLES, 8, ignition trial window in cycles (>=2)
PROVE_CYCLES, 4, consecutive flame-high cycles required to prove flame (>=1)
COOL_CYCLES, 32, post-purge and minimum alarm dwell in cycles (>=2)
MAX_RETRIES, 3, failed trials before lockout (1..3)
MIN_FLOW, 10, massflow must be strictly greater than this to start
CO_LIMIT, 100, CO trip when CO > CO_LIMIT
ETH_LIMIT, 50, ethanol trip when ethanol > ETH_LIMIT
TEMP_MAX, 1000, over-temperature trip when temperature > TEMP_MAX

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  level request to light the burner
stop  in  1  level request for normal shutdown
lockout_clr  in  1  operator clear; honoured only in LOCKOUT
flame  in  1  flame-detector input, already synchronised
CO  in  8  CO sensor reading
ethanol  in  8  ethanol sensor reading
massflow  in  12  air mass-flow reading
temperature  in  16  chamber temperature
fault  in  1  external fault, active-high
fan  out  1  combustion-air fan
valve  out  1  gas valve
solenoid  out  1  fuel solenoid
pump  out  1  fuel pump
igniter  out  1  spark igniter
alarm  out  1  high in ALARM and LOCKOUT
lockout  out  1  high only in LOCKOUT
state  out  3  current state code
retry_cnt  out  2  failed ignition trials since the last start

Behaviour:
- Synchronous reset: state = IDLE (0); all outputs 0; timer = 0; retry_cnt = 0. Reset mid-sequence de-energises every actuator on the next edge.
- Outputs are Moore, decoded from the registered state. They change on the same edge as state.
- States, codes and outputs:
  - IDLE = 0: all actuators off.
  - PURGE = 1: fan on.
  - IGNITE = 2: fan, valve, solenoid and igniter on.
  - PROVE = 3: fan, valve and solenoid on; igniter off.
  - RUN = 4: fan, valve, solenoid and pump on.
  - POSTPURGE = 5: fan on.
  - ALARM = 6: fan and alarm on.
  - LOCKOUT = 7: fan, alarm and lockout on.
- hazard = (CO > CO_LIMIT) | (ethanol > ETH_LIMIT) | (temperature > TEMP_MAX) | fault. All comparisons are unsigned and full input width.
- Priority per cycle: reset > hazard > stop > normal transition.
- Hazard forces ALARM from PURGE, IGNITE, PROVE, RUN and POSTPURGE. In IDLE, hazard only blocks start. In LOCKOUT, hazard blocks the clear.
- Stop forces POSTPURGE from PURGE, IGNITE, PROVE and RUN.
- Dwell timer: 16-bit, cleared on every state change, increments each cycle while the state is held, saturates at 0xFFFF.
- Transitions:
  - IDLE -> PURGE when start & !stop & !hazard & massflow > MIN_FLOW. retry_cnt is cleared on this transition.
  - PURGE -> IGNITE when timer == PURGE_CYCLES-1. PURGE therefore lasts exactly PURGE_CYCLES cycles.
  - IGNITE -> PROVE when flame = 1.
  - Failed trial (IGNITE with timer == IGN_CYCLES-1 and flame = 0, or flame = 0 in any PROVE cycle):
    - if retry_cnt+1 == MAX_RETRIES -> LOCKOUT;
    - else -> PURGE (re-purge).
    - retry_cnt increments in both cases and saturates at 3.
  - PROVE -> RUN when flame has been 1 for PROVE_CYCLES consecutive PROVE cycles (timer == PROVE_CYCLES-1 with flame = 1). retry_cnt is cleared on entering RUN.
  - RUN -> ALARM on flame = 0 (flame loss is treated as a hazard).
  - POSTPURGE -> IDLE when timer == COOL_CYCLES-1.
  - ALARM -> IDLE when timer >= COOL_CYCLES-1 and hazard = 0. Otherwise ALARM holds, with the timer saturating.
  - LOCKOUT -> IDLE only when lockout_clr = 1 and hazard = 0. lockout_clr is ignored in every other state.
- Simultaneous events:
  - flame and the IGNITE timeout in the same cycle: flame wins (go to PROVE).
  - start and stop both high in IDLE: stay in IDLE.

Test Plan:
- Nominal light-off: massflow = 20, start = 1; flame rises 3 cycles into IGNITE -> PURGE for 16 cycles, IGNITE, PROVE for 4 cycles, then RUN with fan/valve/solenoid/pump = 1, igniter = 0, retry_cnt = 0.
- Retry to lockout: flame held 0 -> three IGNITE windows of 8 cycles, each separated by a 16-cycle PURGE; retry_cnt steps 1, 2; third failure -> LOCKOUT (state = 7, lockout = alarm = fan = 1). lockout_clr with fault = 1 -> stays; with fault = 0 -> IDLE next cycle.
- Gas trip in RUN: CO = 101 -> ALARM next edge, valve = solenoid = pump = 0, fan = 1. CO back to 100 at alarm cycle 10 -> IDLE after 32 alarm cycles. With CO = 101 held 50 cycles -> stays in ALARM until cleared.
- Boundary thresholds: ethanol = 50, temperature = 1000, massflow = 11 -> no trip and start accepted. massflow = 10 -> start ignored, stays in IDLE.
- Flame flicker in PROVE: flame drops in the 2nd PROVE cycle -> PURGE with retry_cnt = 1. Stop asserted in RUN -> POSTPURGE (fan only) for 32 cycles, then IDLE.
- Reset mid-IGNITE: assert reset for 1 cycle -> all outputs 0, state = 0, retry_cnt = 0 on the next edge. Simultaneous flame and timeout at IGNITE cycle 7 -> PROVE.
